// File: rtl/otp_auth_pkg.sv
// Shared encodings and helpers for the one-time-password authentication controller.
package otp_auth_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ENTRY    = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_UNLOCKED = 3'd3;
  localparam logic [2:0] ST_LOCKED   = 3'd4;
  localparam logic [2:0] ST_EXPIRED  = 3'd5;

  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Taps for x^16+x^14+x^13+x^11+1 as bit indices of a left-shifting register.
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  function automatic logic [3:0] fold_nibble(input logic [3:0] n);
    return (n > 4'd9) ? (n - 4'd10) : n;
  endfunction

  function automatic logic [15:0] fold_otp(input logic [15:0] v);
    return {fold_nibble(v[15:12]), fold_nibble(v[11:8]),
            fold_nibble(v[7:4]), fold_nibble(v[3:0])};
  endfunction

endpackage

// File: rtl/otp_auth_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR feeding the OTP capture register.
module lfsr16
  import otp_auth_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic        fb;

  assign fb  = q_q[TAP_A] ^ q_q[TAP_B] ^ q_q[TAP_C] ^ q_q[TAP_D];
  assign q_d = {q_q[14:0], fb};
  assign q   = q_q;

  // Shift register state, advancing every cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/otp_auth_ctrl.sv
// OTP authentication controller: session FSM, digit shifter, attempt counter,
// expiry timer and registered status outputs for the BCD display stage.
module otp_auth_ctrl
  import otp_auth_pkg::*;
#(
  parameter int          EXPIRE_CYCLES = 1000,
  parameter int          MAX_ATT       = 3,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gen,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        enter,
  output logic [15:0] lfsr_otp,
  output logic [15:0] user_otp,
  output logic        unlock,
  output logic        lock,
  output logic        expire,
  output logic [1:0]  wrng_att
);

  localparam int            TW         = (EXPIRE_CYCLES > 2) ? $clog2(EXPIRE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(EXPIRE_CYCLES - 1);
  localparam logic [2:0]    MAX_ATT_W  = 3'(MAX_ATT);

  logic [15:0]   lfsr_s;
  logic [2:0]    state_q, state_d;
  logic [15:0]   otp_q, otp_d;
  logic [15:0]   user_q, user_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    att_q, att_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unlock_q, lock_q, expire_q;
  logic          start_s, clr_att_s;
  logic [TW-1:0] timer_dec_s;
  logic [2:0]    att_inc_s;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_s)
  );

  // The timer saturates at zero so expiry seen from CHECK lands on the next ENTRY cycle.
  assign timer_dec_s = (timer_q != {TW{1'b0}}) ? (timer_q - {{(TW-1){1'b0}}, 1'b1}) : timer_q;
  assign att_inc_s   = {1'b0, att_q} + 3'd1;

  // Next-state logic for the session FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    otp_d     = otp_q;
    user_d    = user_q;
    cnt_d     = cnt_q;
    att_d     = att_q;
    timer_d   = timer_q;
    start_s   = 1'b0;
    clr_att_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_UNLOCKED, ST_EXPIRED: begin
        if (gen) begin
          start_s   = 1'b1;
          clr_att_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_ENTRY: begin
        if (timer_q == {TW{1'b0}}) begin
          state_d = ST_EXPIRED;
        end else begin
          timer_d = timer_dec_s;
          if (gen) begin
            start_s = 1'b1;
          end else if (enter) begin
            if (cnt_q == 3'd4) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_ENTRY;
            end
          end else if (digit_valid && (digit <= 4'd9) && (cnt_q < 3'd4)) begin
            user_d = {user_q[11:0], digit};
            cnt_d  = cnt_q + 3'd1;
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end
      ST_CHECK: begin
        timer_d = timer_dec_s;
        if (user_q == otp_q) begin
          state_d = ST_UNLOCKED;
        end else if (att_inc_s == MAX_ATT_W) begin
          state_d = ST_LOCKED;
        end else begin
          att_d   = att_inc_s[1:0];
          user_d  = 16'h0000;
          cnt_d   = 3'd0;
          state_d = ST_ENTRY;
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_s) begin
      otp_d   = fold_otp(lfsr_s);
      timer_d = TIMER_LOAD;
      user_d  = 16'h0000;
      cnt_d   = 3'd0;
      state_d = ST_ENTRY;
    end else begin
      otp_d = otp_d;
    end

    if (clr_att_s) begin
      att_d = 2'd0;
    end else begin
      att_d = att_d;
    end
  end

  // State, datapath and flag registers; flags follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      otp_q    <= 16'h0000;
      user_q   <= 16'h0000;
      cnt_q    <= 3'd0;
      att_q    <= 2'd0;
      timer_q  <= {TW{1'b0}};
      unlock_q <= 1'b0;
      lock_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      otp_q    <= otp_d;
      user_q   <= user_d;
      cnt_q    <= cnt_d;
      att_q    <= att_d;
      timer_q  <= timer_d;
      unlock_q <= (state_d == ST_UNLOCKED);
      lock_q   <= (state_d == ST_LOCKED);
      expire_q <= (state_d == ST_EXPIRED);
    end
  end

  assign lfsr_otp = otp_q;
  assign user_otp = user_q;
  assign unlock   = unlock_q;
  assign lock     = lock_q;
  assign expire   = expire_q;
  assign wrng_att = att_q;

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Self-checking bench for otp_auth_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural session model.
module tb_otp_auth_ctrl;

  localparam int          EXP  = 20;
  localparam int          MAXA = 3;
  localparam logic [15:0] SEED = 16'hFA93;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_UNL = 3, M_LOCK = 4, M_EXP = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gen = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        enter = 1'b0;
  logic [15:0] lfsr_otp, user_otp;
  logic        unlock, lock, expire;
  logic [1:0]  wrng_att;

  int errors = 0;
  int checks = 0;

  int m_st, m_att, m_age, m_lfsr;
  int m_otp[4];
  int m_dig[$];

  otp_auth_ctrl #(.EXPIRE_CYCLES(EXP), .MAX_ATT(MAXA), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .gen(gen), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .lfsr_otp(lfsr_otp), .user_otp(user_otp), .unlock(unlock),
    .lock(lock), .expire(expire), .wrng_att(wrng_att)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic logic [15:0] exp_otp();
    int v = 0;
    for (int i = 0; i < 4; i++) v = v * 16 + m_otp[i];
    return 16'(v);
  endfunction

  function automatic logic [15:0] exp_user();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_att = 0; m_age = 0; m_lfsr = int'(SEED);
    m_dig.delete();
    for (int i = 0; i < 4; i++) m_otp[i] = 0;
  endtask

  task automatic model_start(input bit clr_att);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = (m_lfsr >> (12 - 4 * i)) & 15;
      m_otp[i] = (n > 9) ? n - 10 : n;
    end
    m_dig.delete();
    m_age = 0;
    m_st  = M_ENTRY;
    if (clr_att) m_att = 0;
  endtask

  task automatic model_step(input bit g, input bit dv, input int d, input bit e);
    bit match;
    case (m_st)
      M_IDLE, M_UNL, M_EXP: if (g) model_start(1'b1);
      M_ENTRY: begin
        if (m_age + 1 >= EXP) begin
          m_st = M_EXP;
          m_age++;
        end else if (g) begin
          model_start(1'b0);
        end else begin
          m_age++;
          if (e) begin
            if (m_dig.size() == 4) m_st = M_CHECK;
          end else if (dv && d <= 9 && m_dig.size() < 4) begin
            m_dig.push_back(d);
          end
        end
      end
      M_CHECK: begin
        m_age++;
        match = 1'b1;
        for (int i = 0; i < 4; i++) if (m_dig[i] != m_otp[i]) match = 1'b0;
        if (match) m_st = M_UNL;
        else if (m_att + 1 == MAXA) m_st = M_LOCK;
        else begin
          m_att++;
          m_dig.delete();
          m_st = M_ENTRY;
        end
      end
      default: ;
    endcase
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check_all();
    chk("lfsr_otp", lfsr_otp, exp_otp());
    chk("user_otp", user_otp, exp_user());
    chk("unlock", {15'd0, unlock}, {15'd0, m_st == M_UNL});
    chk("lock", {15'd0, lock}, {15'd0, m_st == M_LOCK});
    chk("expire", {15'd0, expire}, {15'd0, m_st == M_EXP});
    chk("wrng_att", {14'd0, wrng_att}, 16'(m_att));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare after it.
  task automatic tick(input bit g, input bit dv, input int d, input bit e);
    gen = g; digit_valid = dv; digit = 4'(d); enter = e;
    @(posedge clk);
    model_step(g, dv, d, e);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; gen = 1'b0; digit_valid = 1'b0; digit = 4'd0; enter = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic key_code(input bit wrong);
    for (int i = 0; i < 4; i++) begin
      int dd;
      dd = m_otp[i];
      if (wrong && i == 3) dd = (dd + 1) % 10;
      tick(1'b0, 1'b1, dd, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Fold and correct code
    tick(1'b1, 1'b0, 0, 1'b0);
    chk("fold_5093", lfsr_otp, 16'h5093);
    key_code(1'b0);
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("check_no_unlock", {15'd0, unlock}, 16'd0);
    tick(1'b0, 1'b0, 0, 1'b0);
    chk("unlock_after_2", {15'd0, unlock}, 16'd1);
    chk("unlock_att0", {14'd0, wrng_att}, 16'd0);

    // Lockout
    tick(1'b1, 1'b0, 0, 1'b0);
    for (int a = 1; a <= 3; a++) begin
      key_code(1'b1);
      tick(1'b0, 1'b0, 0, 1'b1);
      tick(1'b0, 1'b0, 0, 1'b0);
      if (a < 3) chk("att_step", {14'd0, wrng_att}, 16'(a));
    end
    chk("locked", {15'd0, lock}, 16'd1);
    chk("locked_att", {14'd0, wrng_att}, 16'd2);
    tick(1'b1, 1'b0, 0, 1'b0);
    key_code(1'b0);
    tick(1'b0, 1'b0, 0, 1'b1);
    tick(1'b0, 1'b0, 0, 1'b0);
    chk("lock_absorbs", {15'd0, lock}, 16'd1);
    @(negedge clk);
    do_reset();

    // Expiry exactly EXP cycles after gen
    tick(1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i < EXP; i++) tick(1'b0, 1'b0, 0, 1'b0);
    chk("no_expire_early", {15'd0, expire}, 16'd0);
    tick(1'b0, 1'b0, 0, 1'b0);
    chk("expire_at_N", {15'd0, expire}, 16'd1);
    tick(1'b1, 1'b0, 0, 1'b0);
    chk("expire_cleared", {15'd0, expire}, 16'd0);

    // Entry rules
    tick(1'b1, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b1, 3, 1'b0);
    tick(1'b0, 1'b1, 12, 1'b0);
    tick(1'b0, 1'b1, 7, 1'b0);
    tick(1'b0, 1'b1, 1, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("short_enter_user", user_otp, 16'h0371);
    chk("short_enter_flags", {13'd0, unlock, lock, expire}, 16'd0);
    tick(1'b0, 1'b1, 5, 1'b0);
    tick(1'b0, 1'b1, 9, 1'b0);
    chk("user_3715", user_otp, 16'h3715);

    // Enter on the cycle the timer reaches zero
    @(negedge clk);
    do_reset();
    tick(1'b1, 1'b0, 0, 1'b0);
    key_code(1'b1);
    tick(1'b0, 1'b0, 0, 1'b1);
    tick(1'b0, 1'b0, 0, 1'b0);
    key_code(1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("enter_at_zero_expire", {15'd0, expire}, 16'd1);
    chk("enter_at_zero_att", {14'd0, wrng_att}, 16'd1);

    // Asynchronous reset while in CHECK
    tick(1'b1, 1'b0, 0, 1'b0);
    key_code(1'b0);
    tick(1'b0, 1'b0, 0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        lfsr_otp | user_otp | {11'd0, unlock, lock, expire, wrng_att}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 0, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit g, dv, e;
      int d;
      if (m_st == M_LOCK && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else begin
        g  = ($urandom_range(0, 24) == 0);
        e  = ($urandom_range(0, 5) == 0);
        dv = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) != 0) d = m_otp[(m_dig.size() < 4) ? m_dig.size() : 0];
        else d = int'($urandom_range(0, 15));
        tick(g, dv, d, e);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
